// File: rtl/sodor_scratchpad_responder.sv
// Scratchpad responder: answers each accepted request with a registered response one cycle later.
// Latency 1 cycle; there is no backpressure, so every valid request is accepted and answered.
module sodor_scratchpad_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned SIZE_BYTES = 262144,
  parameter int unsigned WORDS      = SIZE_BYTES / 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  input  logic [31:0] io_req_bits_addr,
  input  logic [31:0] io_req_bits_data,
  input  logic        io_req_bits_fcn,
  input  logic [2:0]  io_req_bits_typ,
  output logic        io_resp_valid,
  output logic [31:0] io_resp_bits_data,
  output logic        io_resp_bits_err,
  output logic [31:0] io_resp_addr
);

  localparam int unsigned IDX_W       = $clog2(WORDS);
  localparam logic [31:0] OFFSET_MASK = 32'(SIZE_BYTES - 1);

  logic [31:0]      mem [WORDS];

  logic             inRange;
  logic             reqErr;
  logic             typUnsigned;
  logic [1:0]       typSize;
  logic [1:0]       lane;
  logic [IDX_W-1:0] wordIdx;
  logic [3:0]       byteEn;
  logic [31:0]      wrWord;
  logic [31:0]      rdWord;
  logic [7:0]       rdByte;
  logic [15:0]      rdHalf;
  logic [31:0]      rdData;

  // typ[1:0] encodes size (0 = illegal), typ[2] selects zero-extension.
  always_comb begin
    inRange     = ((io_req_bits_addr ^ ADDR_BASE) & ~OFFSET_MASK) == 32'd0;
    wordIdx     = io_req_bits_addr[IDX_W+1:2];
    lane        = io_req_bits_addr[1:0];
    typSize     = io_req_bits_typ[1:0];
    typUnsigned = io_req_bits_typ[2];
    reqErr      = !inRange
               || (typSize == 2'd0)
               || ((typSize == 2'd2) && lane[0])
               || ((typSize == 2'd3) && (lane != 2'd0));
  end

  always_comb begin
    byteEn = 4'b1111;
    wrWord = io_req_bits_data;
    case (typSize)
      2'd1: begin
        byteEn = 4'b0001 << lane;
        wrWord = {4{io_req_bits_data[7:0]}};
      end
      2'd2: begin
        byteEn = lane[1] ? 4'b1100 : 4'b0011;
        wrWord = {2{io_req_bits_data[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrWord = io_req_bits_data;
      end
    endcase
  end

  always_comb begin
    rdWord = mem[wordIdx];
    rdByte = rdWord[{lane, 3'b000} +: 8];
    rdHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];
    case (typSize)
      2'd1:    rdData = typUnsigned ? {24'd0, rdByte} : {{24{rdByte[7]}}, rdByte};
      2'd2:    rdData = typUnsigned ? {16'd0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
      default: rdData = rdWord;
    endcase
  end

  // Array is never reset; the async-reset branch simply suppresses writes while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_resp_valid     <= 1'b0;
      io_resp_bits_data <= 32'd0;
      io_resp_bits_err  <= 1'b0;
      io_resp_addr      <= 32'd0;
    end else begin
      io_resp_valid <= io_req_valid;
      if (io_req_valid) begin
        io_resp_addr      <= io_req_bits_addr;
        io_resp_bits_err  <= reqErr;
        io_resp_bits_data <= (!io_req_bits_fcn && !reqErr) ? rdData : 32'd0;
        if (io_req_bits_fcn && !reqErr) begin
          for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
          end
        end
      end
    end
  end

endmodule
